// File: rtl/mx_tx_arb_pkg.sv
// Shared types for the two-source packet transmit arbiter: FSM states,
// the packet word layout and the source indices.
package mx_tx_arb_pkg;

  localparam int PKT_DATA_W  = 64;
  localparam int PKT_EMPTY_W = 3;

  localparam int SRC_TG  = 0;
  localparam int SRC_CPU = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [PKT_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [PKT_EMPTY_W-1:0] empty;
  } pkt_word_t;

endpackage

// File: rtl/mx_tx_arb_grant.sv
// Winner selection for the packet arbiter: strict priority (source 1 first)
// or round-robin alternation away from the last granted source.
module mx_tx_arb_grant
  import mx_tx_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       strict_prio_i,
  input  logic       rr_last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (strict_prio_i) begin
      if (req_i[SRC_CPU])     grant_o[SRC_CPU] = 1'b1;
      else if (req_i[SRC_TG]) grant_o[SRC_TG]  = 1'b1;
    end else if (&req_i) begin
      // Contention: the source that did not win last time goes next.
      grant_o = rr_last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/mx_tx_pkt_arbiter.sv
// Packet-granular arbiter sharing the transmit path between the traffic
// generator and the CPU stream; grant is held from SOP until the EOP transfer.
module mx_tx_pkt_arbiter
  import mx_tx_arb_pkg::*;
#(
  parameter int DATA_W  = PKT_DATA_W,
  parameter int EMPTY_W = PKT_EMPTY_W,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  src0_data_i,
  input  logic               src0_sop_i,
  input  logic               src0_eop_i,
  input  logic [EMPTY_W-1:0] src0_empty_i,
  input  logic               src0_val_i,
  output logic               src0_ready_o,
  input  logic [DATA_W-1:0]  src1_data_i,
  input  logic               src1_sop_i,
  input  logic               src1_eop_i,
  input  logic [EMPTY_W-1:0] src1_empty_i,
  input  logic               src1_val_i,
  output logic               src1_ready_o,
  output logic [DATA_W-1:0]  tx_data_o,
  output logic               tx_sop_o,
  output logic               tx_eop_o,
  output logic [EMPTY_W-1:0] tx_empty_o,
  output logic               tx_val_o,
  input  logic               tx_ready_i,
  input  logic [1:0]         src_en_i,
  input  logic               strict_prio_i,
  output logic [CNT_W-1:0]   pkt_cnt0_o,
  output logic [CNT_W-1:0]   pkt_cnt1_o,
  output logic               proto_err_o,
  input  logic               err_clr_i
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_rr_last;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;
  logic             r_proto_err;

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic [1:0] w_stray;
  logic       w_xfer;
  logic       w_eop_xfer;
  pkt_word_t  w_src0_word;
  pkt_word_t  w_src1_word;
  pkt_word_t  w_tx_word;

  assign w_src0_word = '{data: src0_data_i, sop: src0_sop_i, eop: src0_eop_i, empty: src0_empty_i};
  assign w_src1_word = '{data: src1_data_i, sop: src1_sop_i, eop: src1_eop_i, empty: src1_empty_i};

  assign w_req   = src_en_i & {src1_val_i & src1_sop_i,  src0_val_i & src0_sop_i};
  assign w_stray = src_en_i & {src1_val_i & ~src1_sop_i, src0_val_i & ~src0_sop_i};

  mx_tx_arb_grant u_grant (
    .req_i         (w_req),
    .strict_prio_i (strict_prio_i),
    .rr_last_i     (r_rr_last),
    .grant_o       (w_grant)
  );

  assign w_tx_word  = (r_state == ST_GRANT1) ? w_src1_word : w_src0_word;
  assign w_xfer     = tx_val_o & tx_ready_i;
  assign w_eop_xfer = w_xfer & w_tx_word.eop;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant[SRC_CPU])     w_state_nxt = ST_GRANT1;
        else if (w_grant[SRC_TG]) w_state_nxt = ST_GRANT0;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (w_eop_xfer) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshakes are held off during reset so a half-sent packet is dropped cleanly.
  always_comb begin
    tx_val_o     = 1'b0;
    src0_ready_o = 1'b0;
    src1_ready_o = 1'b0;
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          src0_ready_o = w_stray[SRC_TG];
          src1_ready_o = w_stray[SRC_CPU];
        end
        ST_GRANT0: begin
          tx_val_o     = src0_val_i;
          src0_ready_o = tx_ready_i;
        end
        ST_GRANT1: begin
          tx_val_o     = src1_val_i;
          src1_ready_o = tx_ready_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_last   <= 1'b1;
      r_pkt_cnt0  <= '0;
      r_pkt_cnt1  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && |w_grant) r_rr_last <= w_grant[SRC_CPU];
      if (r_state == ST_GRANT0 && w_eop_xfer) r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
      if (r_state == ST_GRANT1 && w_eop_xfer) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
      if (r_state == ST_IDLE && |w_stray) r_proto_err <= 1'b1;
      else if (err_clr_i)                 r_proto_err <= 1'b0;
    end
  end

  assign tx_data_o   = w_tx_word.data;
  assign tx_sop_o    = w_tx_word.sop;
  assign tx_eop_o    = w_tx_word.eop;
  assign tx_empty_o  = w_tx_word.empty;
  assign pkt_cnt0_o  = r_pkt_cnt0;
  assign pkt_cnt1_o  = r_pkt_cnt1;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_mx_tx_pkt_arbiter.sv
// Scoreboard bench for mx_tx_pkt_arbiter: source queues drive the inputs,
// expected tx words are queued in hand-computed order and checked by a monitor.
module tb_mx_tx_pkt_arbiter;
  import mx_tx_arb_pkg::*;

  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int CNT_W   = 32;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [DATA_W-1:0]  src0_data_i, src1_data_i;
  logic               src0_sop_i, src0_eop_i, src0_val_i, src0_ready_o;
  logic               src1_sop_i, src1_eop_i, src1_val_i, src1_ready_o;
  logic [EMPTY_W-1:0] src0_empty_i, src1_empty_i;
  logic [DATA_W-1:0]  tx_data_o;
  logic               tx_sop_o, tx_eop_o, tx_val_o, tx_ready_i;
  logic [EMPTY_W-1:0] tx_empty_o;
  logic [1:0]         src_en_i;
  logic               strict_prio_i;
  logic [CNT_W-1:0]   pkt_cnt0_o, pkt_cnt1_o;
  logic               proto_err_o;
  logic               err_clr_i;

  mx_tx_pkt_arbiter #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .src0_data_i(src0_data_i), .src0_sop_i(src0_sop_i), .src0_eop_i(src0_eop_i),
    .src0_empty_i(src0_empty_i), .src0_val_i(src0_val_i), .src0_ready_o(src0_ready_o),
    .src1_data_i(src1_data_i), .src1_sop_i(src1_sop_i), .src1_eop_i(src1_eop_i),
    .src1_empty_i(src1_empty_i), .src1_val_i(src1_val_i), .src1_ready_o(src1_ready_o),
    .tx_data_o(tx_data_o), .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o),
    .tx_empty_o(tx_empty_o), .tx_val_o(tx_val_o), .tx_ready_i(tx_ready_i),
    .src_en_i(src_en_i), .strict_prio_i(strict_prio_i),
    .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o),
    .proto_err_o(proto_err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int        n_chk  = 0;
  int        n_fail = 0;
  pkt_word_t q0[$];
  pkt_word_t q1[$];
  pkt_word_t sb[$];
  logic      rdy_q[$];
  logic      bp_chk   = 1'b0;
  logic      prev_eop = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted tx word must be the next expected one.
  always @(negedge clk_i) begin
    pkt_word_t act, exp;
    if (prev_eop) chk("bubble_after_eop", 128'(tx_val_o), 128'(1'b0));
    prev_eop = 1'b0;
    if (bp_chk && dut.r_state == ST_GRANT1) begin
      chk("bp_src1_ready", 128'(src1_ready_o), 128'(tx_ready_i));
      chk("bp_src0_ready", 128'(src0_ready_o), 128'(1'b0));
    end
    if (tx_val_o && tx_ready_i) begin
      act = '{data: tx_data_o, sop: tx_sop_o, eop: tx_eop_o, empty: tx_empty_o};
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: actual %0h required none", act);
      end else begin
        exp = sb.pop_front();
        chk("tx_word", 128'(act), 128'(exp));
        prev_eop = tx_eop_o;
      end
    end
  end

  task automatic drive_heads();
    if (q0.size() != 0) begin
      src0_val_i = 1'b1;
      {src0_data_i, src0_sop_i, src0_eop_i, src0_empty_i} = q0[0];
    end else begin
      src0_val_i = 1'b0;
      {src0_data_i, src0_sop_i, src0_eop_i, src0_empty_i} = '0;
    end
    if (q1.size() != 0) begin
      src1_val_i = 1'b1;
      {src1_data_i, src1_sop_i, src1_eop_i, src1_empty_i} = q1[0];
    end else begin
      src1_val_i = 1'b0;
      {src1_data_i, src1_sop_i, src1_eop_i, src1_empty_i} = '0;
    end
    tx_ready_i = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
  endtask

  task automatic step();
    logic a0, a1;
    @(negedge clk_i);
    a0 = src0_val_i & src0_ready_o;
    a1 = src1_val_i & src1_ready_o;
    @(posedge clk_i);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive_heads();
  endtask

  task automatic run(int maxc);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    n_chk++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL run_timeout: actual %0d cycles required fewer than %0d", c, maxc);
    end
  endtask

  task automatic add_pkt(int src, int pkt, int n, bit exp);
    pkt_word_t x;
    for (int w = 0; w < n; w++) begin
      x.data  = 64'hC0DE_0000_0000_0000 | (64'(src) << 16) | (64'(pkt) << 8) | 64'(w);
      x.sop   = (w == 0);
      x.eop   = (w == n - 1);
      x.empty = x.eop ? 3'(pkt + 4) : 3'd0;
      if (src == 0) q0.push_back(x);
      else          q1.push_back(x);
      if (exp) sb.push_back(x);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    q0.delete(); q1.delete(); sb.delete(); rdy_q.delete();
    drive_heads();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic clr_err();
    @(posedge clk_i); #1; err_clr_i = 1'b1;
    @(posedge clk_i); #1; err_clr_i = 1'b0;
  endtask

  initial begin
    pkt_word_t s;
    int c;
    s = '{data: 64'hBAD0, sop: 1'b0, eop: 1'b0, empty: 3'd0};
    rst_i = 1'b1; src_en_i = 2'b11; strict_prio_i = 1'b0; err_clr_i = 1'b0;
    do_reset();

    @(negedge clk_i);
    chk("rst_tx_val", 128'(tx_val_o), 128'(1'b0));
    chk("rst_ready0", 128'(src0_ready_o), 128'(1'b0));
    chk("rst_ready1", 128'(src1_ready_o), 128'(1'b0));
    chk("rst_cnt0", 128'(pkt_cnt0_o), 128'(0));
    chk("rst_cnt1", 128'(pkt_cnt1_o), 128'(0));
    chk("rst_err", 128'(proto_err_o), 128'(1'b0));
    chk("rst_state", 128'(dut.r_state), 128'(ST_IDLE));

    // Single 3-word packet from source 0
    @(posedge clk_i); #1;
    add_pkt(0, 0, 3, 1);
    drive_heads();
    @(negedge clk_i);
    chk("t1_bubble_val", 128'(tx_val_o), 128'(1'b0));
    chk("t1_bubble_ready0", 128'(src0_ready_o), 128'(1'b0));
    run(50);
    chk("t1_cnt0", 128'(pkt_cnt0_o), 128'(1));
    chk("t1_cnt1", 128'(pkt_cnt1_o), 128'(0));
    chk("t1_state_idle", 128'(dut.r_state), 128'(ST_IDLE));

    // Round-robin: 0,1,0,1,...
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, p, 3, 1);
      add_pkt(1, p, 2, 1);
    end
    drive_heads();
    run(200);
    chk("rr_cnt0", 128'(pkt_cnt0_o), 128'(4));
    chk("rr_cnt1", 128'(pkt_cnt1_o), 128'(4));

    // Strict priority: all source-1 packets first
    do_reset();
    strict_prio_i = 1'b1;
    for (int p = 0; p < 4; p++) add_pkt(1, p, 2, 1);
    for (int p = 0; p < 4; p++) add_pkt(0, p, 3, 1);
    drive_heads();
    run(200);
    chk("sp_cnt0", 128'(pkt_cnt0_o), 128'(4));
    chk("sp_cnt1", 128'(pkt_cnt1_o), 128'(4));

    // Backpressure 1,0,0,1 during a source-1 packet
    do_reset();
    bp_chk = 1'b1;
    add_pkt(1, 0, 4, 1);
    add_pkt(0, 0, 2, 1);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    drive_heads();
    run(100);
    bp_chk = 1'b0;
    strict_prio_i = 1'b0;
    chk("bp_cnt1", 128'(pkt_cnt1_o), 128'(1));
    chk("bp_cnt0", 128'(pkt_cnt0_o), 128'(1));

    // Stray word in IDLE
    do_reset();
    q0.push_back(s);
    drive_heads();
    @(negedge clk_i);
    chk("stray_ready0", 128'(src0_ready_o), 128'(1'b1));
    chk("stray_tx_val", 128'(tx_val_o), 128'(1'b0));
    chk("stray_err_pre", 128'(proto_err_o), 128'(1'b0));
    @(posedge clk_i); #1;
    q0.delete(); drive_heads();
    @(negedge clk_i);
    chk("stray_err_set", 128'(proto_err_o), 128'(1'b1));
    repeat (3) @(negedge clk_i);
    chk("stray_err_sticky", 128'(proto_err_o), 128'(1'b1));
    clr_err();
    @(negedge clk_i);
    chk("err_cleared", 128'(proto_err_o), 128'(1'b0));

    // Clear coinciding with a new stray word: set wins
    @(posedge clk_i); #1;
    q0.push_back(s); drive_heads(); err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0; q0.delete(); drive_heads();
    @(negedge clk_i);
    chk("err_set_wins", 128'(proto_err_o), 128'(1'b1));
    clr_err();

    // Both sources stray in the same cycle
    @(posedge clk_i); #1;
    q0.push_back(s); q1.push_back(s); drive_heads();
    @(negedge clk_i);
    chk("stray2_ready0", 128'(src0_ready_o), 128'(1'b1));
    chk("stray2_ready1", 128'(src1_ready_o), 128'(1'b1));
    @(posedge clk_i); #1;
    q0.delete(); q1.delete(); drive_heads();
    clr_err();

    // Disabled source sees ready 0 and raises no error
    @(posedge clk_i); #1;
    src_en_i = 2'b10; q0.push_back(s); drive_heads();
    @(negedge clk_i);
    chk("dis_ready0", 128'(src0_ready_o), 128'(1'b0));
    @(negedge clk_i);
    chk("dis_no_err", 128'(proto_err_o), 128'(1'b0));
    @(posedge clk_i); #1;
    q0.delete(); drive_heads(); src_en_i = 2'b11;

    // Counter wrap
    do_reset();
    @(negedge clk_i);
    force dut.r_pkt_cnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt0;
    chk("wrap_preload", 128'(pkt_cnt0_o), 128'(32'hFFFF_FFFF));
    @(posedge clk_i); #1;
    add_pkt(0, 2, 2, 1);
    drive_heads();
    run(50);
    chk("wrap_cnt0", 128'(pkt_cnt0_o), 128'(0));

    // Reset mid-packet abandons it
    do_reset();
    add_pkt(0, 1, 4, 0);
    sb.push_back(q0[0]);
    sb.push_back(q0[1]);
    drive_heads();
    c = 0;
    while (sb.size() != 0 && c < 20) begin
      step();
      c++;
    end
    chk("mid_two_words", 128'(sb.size()), 128'(0));
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_tx_val", 128'(tx_val_o), 128'(1'b0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mid_rst_state", 128'(dut.r_state), 128'(ST_IDLE));
    chk("mid_rst_tx_val2", 128'(tx_val_o), 128'(1'b0));
    chk("mid_rst_ready0", 128'(src0_ready_o), 128'(1'b0));
    chk("mid_rst_ready1", 128'(src1_ready_o), 128'(1'b0));
    @(posedge clk_i); #1;
    rst_i = 1'b0; q0.delete(); drive_heads();
    @(negedge clk_i);
    chk("mid_cnt0", 128'(pkt_cnt0_o), 128'(0));
    chk("mid_err", 128'(proto_err_o), 128'(1'b0));

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mx_tx_pkt_arbiter.md
Name: mx_tx_pkt_arbiter

Overview:
- Shares the single 156.25 MHz packet transmit path (towards the dual-PHY transmit interface) between two packet sources.
  - Source 0: traffic generator stream from the traffic engine.
  - Source 1: CPU/network-stack stream.
- Arbitrates at packet granularity and locks the grant until EOP.
- Supports round-robin or strict-priority mode.
- Keeps per-source forwarded-packet counters and a sticky protocol-error flag for nic status.

Parameters:
- DATA_W, 64, data word width.
- EMPTY_W, 3, width of the empty-bytes field on EOP words.
- CNT_W, 32, width of the per-source packet counters.

Ports:
- clk_i  in  1  156.25 MHz clock.
- rst_i  in  1  synchronous reset, active-high.
- src0_data_i  in  DATA_W  traffic-gen data.
- src0_sop_i / src0_eop_i  in  1 each  packet delimiters.
- src0_empty_i  in  EMPTY_W  empty bytes, valid on EOP.
- src0_val_i  in  1  word valid.
- src0_ready_o  out  1  word accepted when val & ready.
- src1_data_i, src1_sop_i, src1_eop_i, src1_empty_i, src1_val_i, src1_ready_o: same as src0, for the CPU source.
- tx_data_o  out  DATA_W  to PHY transmit path.
- tx_sop_o, tx_eop_o  out  1 each.
- tx_empty_o  out  EMPTY_W.
- tx_val_o  out  1.
- tx_ready_i  in  1.
- src_en_i  in  2  per-source enable, sampled only at arbitration.
- strict_prio_i  in  1  1 = source 1 always wins, 0 = round-robin.
- pkt_cnt0_o / pkt_cnt1_o  out  CNT_W  packets forwarded per source.
- proto_err_o  out  1  sticky: word arrived in IDLE without SOP.
- err_clr_i  in  1  clears proto_err_o.

Behaviour:
- Reset values:
  - State = IDLE, rr_last = 1 (so source 0 wins first in round-robin).
  - tx_val_o = 0; src0_ready_o = src1_ready_o = 0.
  - Counters = 0; proto_err_o = 0.
  - Reset asserted mid-packet abandons the packet; no EOP is synthesised.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - req_k = src_en_i[k] & srck_val_i & srck_sop_i.
  - strict_prio_i = 1: req1 wins over req0.
  - strict_prio_i = 0: on simultaneous requests, grant goes to the source other than rr_last; a single request is granted directly.
  - Grant registers: next state is GRANTk, and rr_last is updated to k.
  - One bubble cycle per packet.
  - tx_val_o = 0 in IDLE.
- IDLE, discard of stray words:
  - Applies to an enabled source with val = 1 and sop = 0.
  - That source's ready = 1 in IDLE: the word is discarded and proto_err_o is set.
  - If both sources have stray words in the same cycle, both are discarded.
  - Disabled sources see ready = 0.
- GRANTk:
  - Combinational pass-through, zero latency: tx_* = srck_*, tx_val_o = srck_val_i.
  - srck_ready_o = tx_ready_i; the other source's ready = 0.
  - A word is transferred when tx_val_o & tx_ready_i.
  - A transferred word with EOP returns the FSM to IDLE and increments pkt_cntk_o.
  - src_en_i deasserted mid-packet has no effect; the packet completes.
  - SOP seen mid-packet (missing EOP) is forwarded unchanged; the arbiter does not police it.
- Counters:
  - Free-running modulo 2^CNT_W; they wrap to 0 with no saturation.
- err_clr_i:
  - Clears proto_err_o next cycle.
  - If err_clr_i coincides with a new error, the set wins.
- No combinational path from tx_ready_i to tx_val_o.
- tx_ready_i → srck_ready_o is combinational. This is acceptable; the downstream PHY interface registers it.

Decomposition:
- Shared package mx_tx_arb_pkg holds:
  - typedef enum for states IDLE/GRANT0/GRANT1;
  - packed struct pkt_word_t {data, sop, eop, empty};
  - source-index constants SRC_TG = 0, SRC_CPU = 1.
- One natural sub-module: mx_tx_arb_grant.
  - Purely the winner selection: req vector, strict_prio, rr_last → one-hot grant.
  - Reused later if more sources are added.
- FSM, mux and counters stay in the top.

Test Plan:
- Single source 0, 3-word packet (SOP w0, EOP w2, empty = 4), tx_ready = 1:
  - IDLE → GRANT0 after 1 cycle; tx shows 3 words unchanged;
  - pkt_cnt0 = 1, back to IDLE.
- Both sources request SOP every packet, strict_prio = 0, 4 packets each:
  - output order 0,1,0,1,…, with a 1-cycle bubble between packets;
  - cnt0 = cnt1 = 4.
- Same stimulus with strict_prio = 1:
  - all 4 source-1 packets go first, then source 0's;
  - no interleaving of words inside any packet.
- Backpressure: tx_ready toggled 1,0,0,1 during a GRANT1 packet:
  - src1_ready mirrors tx_ready; src0_ready stays 0;
  - no word is lost or duplicated.
- Source 0 sends val = 1, sop = 0 in IDLE:
  - word is dropped, proto_err_o = 1 and stays set;
  - err_clr_i pulse → 0.
- Preload counter to 2^32−1 (force), then forward 1 packet → cnt = 0.
- Separately, assert rst_i mid-packet:
  - next cycle tx_val = 0, state IDLE, readies 0.
